// File: rtl/risc_v_muldiv_unit.sv
// rtl/risc_v_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EXECUTE stage
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fixed up at the end.
module risc_v_muldiv_unit #(
  parameter int LENGTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic [2:0]        i_funct3,
  input  logic [LENGTH-1:0] i_a,
  input  logic [LENGTH-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [LENGTH-1:0] o_result
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LENGTH);
  localparam logic [LENGTH-1:0] MOST_NEG = {1'b1, {(LENGTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0]          funct3_q, funct3_d;
  logic                neg_q, neg_d;
  logic                spec_q, spec_d;
  logic [LENGTH-1:0]   spec_res_q, spec_res_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LENGTH-1:0]   mcand_q, mcand_d;
  logic [2*LENGTH-1:0] prod_q, prod_d;
  logic [LENGTH-1:0]   dvsr_q, dvsr_d;
  logic [LENGTH-1:0]   quo_q, quo_d;
  logic [LENGTH:0]     rem_q, rem_d;
  logic [LENGTH-1:0]   result_q, result_d;
  logic                done_q, done_d;

  logic start_fire, calc_step, fix_fire;

  logic a_signed, b_signed, a_neg, b_neg, is_div, is_rem;
  logic div_by_zero, div_ovf, start_special, start_neg;
  logic [LENGTH-1:0] a_mag, b_mag, special_res;

  always_comb begin
    a_signed    = (i_funct3 != 3'b011) && (i_funct3 != 3'b101) && (i_funct3 != 3'b111);
    b_signed    = a_signed && (i_funct3 != 3'b010);
    a_neg       = a_signed && i_a[LENGTH-1];
    b_neg       = b_signed && i_b[LENGTH-1];
    a_mag       = a_neg ? -i_a : i_a;
    b_mag       = b_neg ? -i_b : i_b;
    is_div      = i_funct3[2];
    is_rem      = i_funct3[2] && i_funct3[1];
    div_by_zero = is_div && (i_b == '0);
    div_ovf     = is_div && !i_funct3[0] && (i_a == MOST_NEG) && (i_b == '1);
    start_special = div_by_zero || div_ovf;
    start_neg   = is_rem ? a_neg : (a_neg ^ b_neg);
    if (div_by_zero) begin
      special_res = is_rem ? i_a : '1;
    end else begin
      special_res = is_rem ? '0 : i_a;
    end
  end

  logic [LENGTH:0]     mul_sum;
  logic [2*LENGTH-1:0] mul_next;
  logic [LENGTH+1:0]   div_shift, div_diff;
  logic                div_borrow;

  // Partial remainder stays below the divisor, so a borrow out of the top bit means "restore".
  always_comb begin
    mul_sum    = {1'b0, prod_q[2*LENGTH-1:LENGTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next   = {mul_sum, prod_q[LENGTH-1:1]};
    div_shift  = {rem_q, quo_q[LENGTH-1]};
    div_diff   = div_shift - {2'b00, dvsr_q};
    div_borrow = div_diff[LENGTH+1];
  end

  logic [2*LENGTH-1:0] prod_fix;
  logic [LENGTH-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_fix  = neg_q ? -rem_q[LENGTH-1:0] : rem_q[LENGTH-1:0];
    if (spec_q) begin
      fix_res = spec_res_q;
    end else begin
      case (funct3_q)
        3'b000:                 fix_res = prod_fix[LENGTH-1:0];
        3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*LENGTH-1:LENGTH];
        3'b100, 3'b101:         fix_res = quo_fix;
        default:                fix_res = rem_fix;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = start_special ? FIX : CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_comb begin
    o_busy     = (state_q != IDLE);
    start_fire = (state_q == IDLE) && i_start && !i_flush;
    calc_step  = (state_q == CALC) && !i_flush;
    fix_fire   = (state_q == FIX) && !i_flush;
  end

  always_comb begin
    funct3_d   = funct3_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    dvsr_d     = dvsr_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    result_d   = result_q;
    done_d     = 1'b0;
    if (start_fire) begin
      funct3_d   = i_funct3;
      neg_d      = start_neg;
      spec_d     = start_special;
      spec_res_d = special_res;
      cnt_d      = CNT_LOAD;
      mcand_d    = a_mag;
      prod_d     = {{LENGTH{1'b0}}, b_mag};
      dvsr_d     = b_mag;
      quo_d      = a_mag;
      rem_d      = '0;
    end else if (calc_step) begin
      cnt_d = cnt_q - CW'(1);
      if (funct3_q[2]) begin
        rem_d = div_borrow ? div_shift[LENGTH:0] : div_diff[LENGTH:0];
        quo_d = {quo_q[LENGTH-2:0], ~div_borrow};
      end else begin
        prod_d = mul_next;
      end
    end
    if (fix_fire) begin
      result_d = fix_res;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      funct3_q   <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      dvsr_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      funct3_q   <= funct3_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      dvsr_q     <= dvsr_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign o_done   = done_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_risc_v_muldiv_unit.sv
// tb/tb_risc_v_muldiv_unit.sv - scoreboard bench for risc_v_muldiv_unit at LENGTH 32 and 8
module tb_risc_v_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start32, flush32, busy32, done32;
  logic [2:0]  f3_32;
  logic [31:0] a32, b32, res32;
  logic        start8, flush8, busy8, done8;
  logic [2:0]  f3_8;
  logic [7:0]  a8, b8, res8;

  risc_v_muldiv_unit #(.LENGTH(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_flush(flush32),
    .i_funct3(f3_32), .i_a(a32), .i_b(b32),
    .o_busy(busy32), .o_done(done32), .o_result(res32)
  );

  risc_v_muldiv_unit #(.LENGTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_flush(flush8),
    .i_funct3(f3_8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_result(res8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q32[$];
  logic [7:0]  q8[$];
  logic [31:0] last32;
  logic [31:0] exp32_m;
  logic [7:0]  exp8_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    logic [31:0] m;
    longint r;
    m = 32'((64'd1 << w) - 64'd1);
    r = longint'({32'd0, v & m});
    if (v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic logic [31:0] model(input int w, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, p, r;
    longint sa, sb, ua, ub, mn;
    mask = (64'd1 << w) - 64'd1;
    sa = sx(a, w);
    sb = sx(b, w);
    ua = longint'({32'd0, a} & mask);
    ub = longint'({32'd0, b} & mask);
    mn = -(longint'(1) << (w - 1));
    case (f3)
      3'd0: begin p = sa * sb; r = p & mask; end
      3'd1: begin p = sa * sb; r = (p >> w) & mask; end
      3'd2: begin p = sa * ub; r = (p >> w) & mask; end
      3'd3: begin p = ua * ub; r = (p >> w) & mask; end
      3'd4: begin
        if (sb == 0) r = mask;
        else if (sa == mn && sb == -1) r = ua;
        else begin p = sa / sb; r = p & mask; end
      end
      3'd5: r = (ub == 0) ? mask : ((ua / ub) & mask);
      3'd6: begin
        if (sb == 0) r = ua;
        else if (sa == mn && sb == -1) r = 64'd0;
        else begin p = sa % sb; r = p & mask; end
      end
      default: r = (ub == 0) ? ua : ((ua % ub) & mask);
    endcase
    return r[31:0];
  endfunction

  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) check("res32_unexpected_done", 64'(done32), 64'd0);
      else begin
        exp32_m = q32.pop_front();
        check("res32", 64'(res32), 64'(exp32_m));
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check("res8_unexpected_done", 64'(done8), 64'd0);
      else begin
        exp8_m = q8.pop_front();
        check("res8", 64'(res8), 64'(exp8_m));
      end
    end
  end

  task automatic issue32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
    f3_32 = f3;
    a32 = a;
    b32 = b;
    start32 = 1'b1;
    if (push) begin
      last32 = model(32, f3, a, b);
      q32.push_back(last32);
    end
  endtask

  // Counts busy cycles and finds the o_done cycle, numbering cycles from the start edge.
  task automatic watch32(input string tag, input int exp_busy, input int exp_done,
                         input int poke_idx, input int flush_idx, input int limit);
    int busy_n;
    int done_at;
    busy_n = 0;
    done_at = -1;
    @(posedge clk);
    #1 start32 = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      busy_n += int'(busy32);
      if (done32) begin
        done_at = i;
        break;
      end
      if (i == poke_idx) begin
        start32 = 1'b1;
        f3_32 = 3'b101;
        a32 = 32'd100;
        b32 = 32'd100;
      end
      if (i == poke_idx + 1) start32 = 1'b0;
      if (i == flush_idx) flush32 = 1'b1;
      if (i == flush_idx + 1) flush32 = 1'b0;
    end
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
  endtask

  task automatic run32(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    bit fast;
    fast = f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    issue32(f3, a, b, 1'b1);
    if (fast) watch32(tag, 1, 1, -5, -5, 45);
    else      watch32(tag, 33, 33, -5, -5, 45);
  endtask

  task automatic run8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b);
    logic [31:0] m;
    bit got;
    m = model(8, f3, {24'd0, a}, {24'd0, b});
    f3_8 = f3;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    q8.push_back(m[7:0]);
    @(posedge clk);
    #1 start8 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        got = 1'b1;
        break;
      end
    end
    check("done8_seen", 64'(got), 64'd1);
  endtask

  logic [7:0] corners [5];

  initial begin
    rst_n = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; f3_32 = 3'd0; a32 = '0; b32 = '0;
    start8 = 1'b0;  flush8 = 1'b0;  f3_8 = 3'd0;  a8 = '0;  b8 = '0;
    last32 = '0;
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy32), 64'd0);
    check("reset_done", 64'(done32), 64'd0);
    check("reset_result", 64'(res32), 64'd0);
    check("reset_busy8", 64'(busy8), 64'd0);
    rst_n = 1'b1;

    run32("mul", 3'b000, 32'd7, 32'hFFFF_FFFD);
    run32("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000);
    run32("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run32("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run32("div", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run32("rem", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run32("divu", 3'b101, 32'd100, 32'd7);
    run32("remu_b2b", 3'b111, 32'd100, 32'd7);
    run32("divu_by0", 3'b101, 32'd5, 32'd0);
    run32("rem_by0", 3'b110, 32'd5, 32'd0);
    run32("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run32("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    issue32(3'b000, 32'd6, 32'd7, 1'b1);
    watch32("ignored_start", 33, 33, 5, -5, 45);

    issue32(3'b000, 32'd3, 32'd5, 1'b0);
    watch32("flush", 11, -1, -5, 10, 45);
    check("flush_result_held", 64'(res32), 64'(last32));

    issue32(3'b001, 32'd9, 32'd9, 1'b0);
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_done", 64'(done32), 64'd0);
    check("midrst_result", 64'(res32), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      run32("rand32", 3'($urandom_range(0, 7)), $urandom,
            (i % 6 == 0) ? 32'd0 : $urandom);
    end

    for (int f = 0; f < 8; f++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          run8(3'(f), corners[x], corners[y]);

    for (int i = 0; i < 600; i++) begin
      case (i % 3)
        0:       run8(3'b001, 8'($urandom), 8'($urandom));
        1:       run8(3'b100, 8'($urandom), 8'($urandom_range(0, 255)));
        default: run8(3'b110, 8'($urandom), 8'($urandom_range(0, 255)));
      endcase
    end
    for (int i = 0; i < 100; i++) run8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

    repeat (5) @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
